// File: rtl/data_memory.sv
// Fixed-latency single-port line memory: one request is outstanding at a time, and ack_o pulses LATENCY edges after acceptance.
// Optional macro DMEM_RANGE_CHECK_EN: requests above the array still ack, but reads return 0 and writes are dropped.
module data_memory #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Handshake: enable_i is sampled only in IDLE. The edge that ends the ack
    // cycle always returns to IDLE without accepting, so a request held high
    // is accepted on the following edge.
    logic [255:0] memory [DEPTH];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [255:0]     wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic             in_range_q, in_range_d;
    logic             ack_q, ack_d;
    logic [255:0]     rdata_q, rdata_d;
    logic             mem_we;
    logic             addr_in_range;
    logic             unused_addr_bits;

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_in_range    = (addr_i[31:5+IDX_W] == '0);
    assign unused_addr_bits = ^addr_i[4:0];
`else
    assign addr_in_range    = 1'b1;
    assign unused_addr_bits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        in_range_d = in_range_q;
        ack_d      = 1'b0;
        rdata_d    = '0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d      = addr_i[5 +: IDX_W];
                    wdata_d    = data_i;
                    wr_d       = write_i;
                    in_range_d = addr_in_range;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (ack_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Commit point: this edge is the LATENCY-th after acceptance.
                    if (cnt_q == LAST_CNT) begin
                        ack_d = 1'b1;
                        if (wr_q) begin
                            mem_we = in_range_q;
                        end else if (in_range_q) begin
                            rdata_d = memory[idx_q];
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            in_range_q <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            in_range_q <= in_range_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage has no reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            memory[idx_q] <= wdata_q;
        end
    end

    assign ack_o       = ack_q;
    assign data_o      = rdata_q;
    assign dbg_state_o = (state_q == BUSY);

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: latency, offset masking, write/read-back, busy lockout, back-to-back, reset and range handling.
module tb_data_memory;

    localparam logic [255:0] P0   = 256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;
    localparam logic [255:0] P16  = 256'h0123456789ABCDEFFEDCBA98765432100123456789ABCDEFFEDCBA9876543210;
    localparam logic [255:0] ECFA = {16{16'hECFA}};
    localparam logic [255:0] P2   = {8{32'hA5A55A5A}};
    localparam logic [255:0] PL   = {4{64'h13579BDF2468ACE0}};
    localparam logic [255:0] WBAD = {8{32'hDEADBEEF}};

    logic         clk;
    logic         rst;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         en;
    logic         wr;
    logic         ack;
    logic [255:0] rdata;
    logic         dbg_state;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    data_memory dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_i      (addr),
        .data_i      (wdata),
        .enable_i    (en),
        .write_i     (wr),
        .ack_o       (ack),
        .data_o      (rdata),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [31:0] a, input logic [255:0] d, input logic w);
        @(negedge clk);
        addr = a;
        wdata = d;
        wr = w;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // Counts edges since acceptance until ack; edges stays -1 if none within 40.
    task automatic wait_ack(input int start, output int edges, output logic [255:0] rd, output int bad);
        edges = -1;
        rd = '0;
        bad = 0;
        for (int i = start + 1; i <= start + 40; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                edges = i;
                rd = rdata;
                break;
            end else if (rdata !== '0) begin
                bad++;
            end
        end
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        cmp_cnt++;
        if (ack !== 1'b0) begin fail_cnt++; $display("FAIL reset_ack: got %b want 0", ack); end
        cmp_cnt++;
        if (rdata !== '0) begin fail_cnt++; $display("FAIL reset_data: got %h want 0", rdata); end
        cmp_cnt++;
        if (dbg_state !== 1'b0) begin fail_cnt++; $display("FAIL reset_state: got %b want 0", dbg_state); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read0;
        int e, bad;
        logic [255:0] rd;
        dut.memory[0] = P0;
        send(32'h0000_0000, '0, 1'b0);
        wait_ack(0, e, rd, bad);
        cmp_cnt++;
        if (e !== 10) begin fail_cnt++; $display("FAIL read0_latency: got %0d want 10", e); end
        cmp_cnt++;
        if (rd !== P0) begin fail_cnt++; $display("FAIL read0_data: got %h want %h", rd, P0); end
        cmp_cnt++;
        if (bad !== 0) begin fail_cnt++; $display("FAIL read0_data_before_ack: got %0d nonzero cycles want 0", bad); end
        @(posedge clk);
        #1;
        cmp_cnt++;
        if (ack !== 1'b0) begin fail_cnt++; $display("FAIL read0_ack_pulse: got %b want 0", ack); end
        cmp_cnt++;
        if (rdata !== '0) begin fail_cnt++; $display("FAIL read0_data_after: got %h want 0", rdata); end
    endtask

    task automatic test_offset;
        int e, bad;
        logic [255:0] rd;
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_0200;
        addrs[1] = 32'h0000_021F;
        dut.memory[16] = P16;
        for (int k = 0; k < 2; k++) begin
            send(addrs[k], '0, 1'b0);
            wait_ack(0, e, rd, bad);
            cmp_cnt++;
            if (e !== 10) begin fail_cnt++; $display("FAIL offset_latency %h: got %0d want 10", addrs[k], e); end
            cmp_cnt++;
            if (rd !== P16) begin fail_cnt++; $display("FAIL offset_data %h: got %h want %h", addrs[k], rd, P16); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_write;
        int e, bad;
        logic [255:0] rd;
        dut.memory[2] = P2;
        dut.memory[34] = '0;
        send(32'h0000_0440, ECFA, 1'b1);
        wait_ack(0, e, rd, bad);
        cmp_cnt++;
        if (e !== 10) begin fail_cnt++; $display("FAIL write_latency: got %0d want 10", e); end
        cmp_cnt++;
        if (rd !== '0) begin fail_cnt++; $display("FAIL write_ack_data: got %h want 0", rd); end
        @(posedge clk);
        #1;
        cmp_cnt++;
        if (dut.memory[34] !== ECFA) begin fail_cnt++; $display("FAIL write_mem34: got %h want %h", dut.memory[34], ECFA); end
        send(32'h0000_0440, '0, 1'b0);
        wait_ack(0, e, rd, bad);
        cmp_cnt++;
        if (rd !== ECFA) begin fail_cnt++; $display("FAIL write_readback: got %h want %h", rd, ECFA); end
        cmp_cnt++;
        if (dut.memory[2] !== P2) begin fail_cnt++; $display("FAIL write_mem2: got %h want %h", dut.memory[2], P2); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore;
        int e, bad, early;
        logic [255:0] rd;
        send(32'h0000_0200, '0, 1'b0);
        addr = 32'h0000_0440;
        wdata = WBAD;
        wr = 1'b1;
        en = 1'b1;
        early = 0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (ack) early++;
        end
        en = 1'b0;
        wait_ack(5, e, rd, bad);
        cmp_cnt++;
        if (early !== 0) begin fail_cnt++; $display("FAIL busy_early_ack: got %0d want 0", early); end
        cmp_cnt++;
        if (e !== 10) begin fail_cnt++; $display("FAIL busy_latency: got %0d want 10", e); end
        cmp_cnt++;
        if (rd !== P16) begin fail_cnt++; $display("FAIL busy_data: got %h want %h", rd, P16); end
        @(posedge clk);
        #1;
        cmp_cnt++;
        if (dut.memory[34] !== ECFA) begin fail_cnt++; $display("FAIL busy_mem34: got %h want %h", dut.memory[34], ECFA); end
    endtask

    task automatic test_back_to_back;
        int n, data_err;
        int ack_at [4];
        n = 0;
        data_err = 0;
        for (int k = 0; k < 4; k++) ack_at[k] = -1;
        dut.memory[0] = P0;
        @(negedge clk);
        addr = 32'h0000_0000;
        wr = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                if (n < 4) ack_at[n] = i;
                n++;
                if (rdata !== P0) data_err++;
            end
        end
        en = 1'b0;
        cmp_cnt++;
        if (n !== 3) begin fail_cnt++; $display("FAIL b2b_ack_count: got %0d want 3", n); end
        cmp_cnt++;
        if (ack_at[0] !== 10) begin fail_cnt++; $display("FAIL b2b_first_ack: got %0d want 10", ack_at[0]); end
        cmp_cnt++;
        if (ack_at[1] !== 22) begin fail_cnt++; $display("FAIL b2b_second_ack: got %0d want 22", ack_at[1]); end
        cmp_cnt++;
        if (ack_at[2] !== 34) begin fail_cnt++; $display("FAIL b2b_third_ack: got %0d want 34", ack_at[2]); end
        cmp_cnt++;
        if (data_err !== 0) begin fail_cnt++; $display("FAIL b2b_data: got %0d bad acks want 0", data_err); end
    endtask

    task automatic test_reset_mid;
        int e, bad, stray;
        logic [255:0] rd;
        dut.memory[0] = P0;
        send(32'h0000_0000, WBAD, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        cmp_cnt++;
        if (ack !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_ack: got %b want 0", ack); end
        cmp_cnt++;
        if (dbg_state !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_state: got %b want 0", dbg_state); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (ack) stray++;
        end
        cmp_cnt++;
        if (stray !== 0) begin fail_cnt++; $display("FAIL rstmid_stray_ack: got %0d want 0", stray); end
        cmp_cnt++;
        if (dut.memory[0] !== P0) begin fail_cnt++; $display("FAIL rstmid_mem0: got %h want %h", dut.memory[0], P0); end
        send(32'h0000_0000, '0, 1'b0);
        wait_ack(0, e, rd, bad);
        cmp_cnt++;
        if (e !== 10) begin fail_cnt++; $display("FAIL rstmid_after_latency: got %0d want 10", e); end
        cmp_cnt++;
        if (rd !== P0) begin fail_cnt++; $display("FAIL rstmid_after_data: got %h want %h", rd, P0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_range;
        int e, bad;
        logic [255:0] rd;
        logic [255:0] exp_rd;
        logic [255:0] exp_m2;
`ifdef DMEM_RANGE_CHECK_EN
        exp_rd = '0;
        exp_m2 = P2;
`else
        exp_rd = P0;
        exp_m2 = WBAD;
`endif
        dut.memory[0] = P0;
        dut.memory[2] = P2;
        send(32'h0000_4000, '0, 1'b0);
        wait_ack(0, e, rd, bad);
        cmp_cnt++;
        if (e !== 10) begin fail_cnt++; $display("FAIL range_read_latency: got %0d want 10", e); end
        cmp_cnt++;
        if (rd !== exp_rd) begin fail_cnt++; $display("FAIL range_read_data: got %h want %h", rd, exp_rd); end
        @(posedge clk);
        #1;
        send(32'h0000_4040, WBAD, 1'b1);
        wait_ack(0, e, rd, bad);
        cmp_cnt++;
        if (e !== 10) begin fail_cnt++; $display("FAIL range_write_latency: got %0d want 10", e); end
        @(posedge clk);
        #1;
        cmp_cnt++;
        if (dut.memory[2] !== exp_m2) begin fail_cnt++; $display("FAIL range_write_mem2: got %h want %h", dut.memory[2], exp_m2); end
    endtask

    task automatic test_last_line;
        int e, bad;
        logic [255:0] rd;
        dut.memory[511] = PL;
        send(32'h0000_3FE0, '0, 1'b0);
        wait_ack(0, e, rd, bad);
        cmp_cnt++;
        if (rd !== PL) begin fail_cnt++; $display("FAIL last_line_data: got %h want %h", rd, PL); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        addr = '0;
        wdata = '0;
        en = 1'b0;
        wr = 1'b0;
        test_reset();
        test_read0();
        test_offset();
        test_write();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_range();
        test_last_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
